// File: rtl/single_predict_if.sv
`default_nettype none
// ============================================================================
//  Module      : single_predict_if
//  Description : Bundle between the image/weight loader and the two-layer
//                inference engine. Every datum is IEEE-754 binary32.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Signals
//    start : one-cycle request from the loader (sampled only in IDLE)
//    x     : input vector            [LAYER1_NEURONS]
//    W1    : layer-1 weights         [LAYER1_NEURONS][LAYER2_NEURONS]
//    b1    : layer-1 biases          [LAYER2_NEURONS]
//    W2    : layer-2 weights         [LAYER2_NEURONS][OUTPUT_NODES]
//    b2    : layer-2 biases          [OUTPUT_NODES]
//    done  : one-cycle pulse, y has just been updated
//    y     : registered raw output scores [OUTPUT_NODES]
//  Modports
//    master : loader side (drives operands, observes results)
//    slave  : engine side
// ============================================================================
interface single_predict_if #(
  parameter int LAYER1_NEURONS = 784,
  parameter int LAYER2_NEURONS = 50,
  parameter int OUTPUT_NODES   = 10
);
  logic        start;
  logic [31:0] x  [LAYER1_NEURONS];
  logic [31:0] W1 [LAYER1_NEURONS][LAYER2_NEURONS];
  logic [31:0] b1 [LAYER2_NEURONS];
  logic [31:0] W2 [LAYER2_NEURONS][OUTPUT_NODES];
  logic [31:0] b2 [OUTPUT_NODES];
  logic        done;
  logic [31:0] y  [OUTPUT_NODES];

  modport master (output start, x, W1, b1, W2, b2, input done, y);
  modport slave  (input start, x, W1, b1, W2, b2, output done, y);
endinterface
`default_nettype wire

// File: rtl/single_predict.sv
`default_nettype none
// ============================================================================
//  Module      : single_predict
//  Description : Two-layer fully-connected inference engine, binary32.
//                hidden = sigmoid(x*W1 + b1), y = hidden*W2 + b2 (raw scores).
//                Fixed accumulation order (bias first, ascending input index)
//                makes results bit-reproducible. Subnormal operands are treated
//                as signed zero and underflowing results flush to signed zero.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk  : rising-edge clock
//    rstn : asynchronous active-low reset
//    bus  : single_predict_if.slave (start/x/W1/b1/W2/b2 in, done/y out)
//  Latency: LAYER1_NEURONS + 2*LAYER2_NEURONS + 1 cycles from the start edge.
//  Parameters must be >= 2.
// ============================================================================
module single_predict #(
  parameter int LAYER1_NEURONS = 784,
  parameter int LAYER2_NEURONS = 50,
  parameter int OUTPUT_NODES   = 10
) (
  input  wire logic          clk,
  input  wire logic          rstn,
  single_predict_if.slave    bus
);
  localparam int K1W = $clog2(LAYER1_NEURONS);
  localparam int K2W = $clog2(LAYER2_NEURONS);
  localparam logic [K1W-1:0] c_L1_LAST = K1W'(LAYER1_NEURONS - 1);
  localparam logic [K2W-1:0] c_L2_LAST = K2W'(LAYER2_NEURONS - 1);
  localparam logic [31:0]    c_QNAN    = 32'h7FC00000;
  localparam logic [31:0]    c_ONE     = 32'h3F800000;

  // ---------------- binary32 arithmetic (round-to-nearest-even) -------------
  function automatic logic is_nan(input logic [31:0] a);
    return (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
  endfunction
  function automatic logic is_inf(input logic [31:0] a);
    return (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
  endfunction
  function automatic logic is_zero(input logic [31:0] a);
    return a[30:23] == 8'h00;
  endfunction

  // Round a normalised 24-bit mantissa (hidden bit at [23]) with guard/sticky.
  function automatic logic [31:0] fpack(input logic s, input logic signed [11:0] e,
                                        input logic [23:0] m, input logic g, input logic st);
    logic [24:0] mr;
    logic signed [11:0] er;
    mr = {1'b0, m} + {24'd0, g & (st | m[0])};
    er = e;
    if (mr[24]) begin
      mr = mr >> 1;
      er = er + 12'sd1;
    end
    if (er >= 12'sd255)   return {s, 8'hFF, 23'd0};
    else if (er <= 12'sd0) return {s, 31'd0};
    else                   return {s, er[7:0], mr[22:0]};
  endfunction

  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic s;
    logic [47:0] p;
    logic signed [11:0] e;
    s = a[31] ^ b[31];
    if (is_nan(a) || is_nan(b) || (is_inf(a) && is_zero(b)) || (is_zero(a) && is_inf(b)))
      return c_QNAN;
    if (is_inf(a) || is_inf(b))   return {s, 8'hFF, 23'd0};
    if (is_zero(a) || is_zero(b)) return {s, 31'd0};
    p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    e = $signed({4'd0, a[30:23]}) + $signed({4'd0, b[30:23]}) - 12'sd127;
    if (p[47]) return fpack(s, e + 12'sd1, p[47:24], p[23], |p[22:0]);
    else       return fpack(s, e, p[46:23], p[22], |p[21:0]);
  endfunction

  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] hi, lo;
    logic [7:0]  d;
    logic [26:0] mh, ml, mask;
    logic [27:0] sum;
    logic signed [11:0] e;
    int pos;
    if (is_nan(a) || is_nan(b) || (is_inf(a) && is_inf(b) && (a[31] != b[31]))) return c_QNAN;
    if (is_inf(a)) return a;
    if (is_inf(b)) return b;
    if (is_zero(a) && is_zero(b)) return {a[31] & b[31], 31'd0};
    if (is_zero(a)) return b;
    if (is_zero(b)) return a;
    if (a[30:0] >= b[30:0]) begin hi = a; lo = b; end
    else                    begin hi = b; lo = a; end
    d  = hi[30:23] - lo[30:23];
    mh = {1'b1, hi[22:0], 3'b000};
    ml = {1'b1, lo[22:0], 3'b000};
    // Alignment shift; bits shifted out collapse into the sticky LSB.
    if (d > 8'd26) ml = 27'd1;
    else begin
      mask = (27'd1 << d) - 27'd1;
      ml   = (ml >> d) | {26'd0, |(ml & mask)};
    end
    e = $signed({4'd0, hi[30:23]});
    if (hi[31] == lo[31]) begin
      sum = {1'b0, mh} + {1'b0, ml};
      if (sum[27]) begin
        sum = {1'b0, sum[27:2], sum[1] | sum[0]};
        e   = e + 12'sd1;
      end
    end else begin
      sum = {1'b0, mh} - {1'b0, ml};
    end
    if (sum == 28'd0) return 32'd0;  // exact cancellation gives +0
    pos = 0;
    for (int i = 0; i < 27; i++) if (sum[i]) pos = i;
    sum = sum << (26 - pos);
    e   = e - $signed(12'(26 - pos));
    return fpack(hi[31], e, sum[26:3], sum[2], sum[1] | sum[0]);
  endfunction

  function automatic logic [31:0] frecip(input logic [31:0] d);
    logic [49:0] num, den;
    logic [26:0] q;
    logic        st;
    if (is_nan(d))  return c_QNAN;
    if (is_inf(d))  return {d[31], 31'd0};
    if (is_zero(d)) return {d[31], 8'hFF, 23'd0};
    num = 50'd1 << 49;
    den = {26'd0, 1'b1, d[22:0]};
    q   = 27'(num / den);
    st  = (num % den) != 50'd0;
    if (q[26]) return fpack(d[31], 12'sd254 - $signed({4'd0, d[30:23]}), q[26:3], q[2], q[1] | q[0] | st);
    else       return fpack(d[31], 12'sd253 - $signed({4'd0, d[30:23]}), q[25:2], q[1], q[0] | st);
  endfunction

  // Round-half-away float->int; only reached for |t| < 256.
  function automatic int f2i(input logic [31:0] t);
    logic [31:0] m;
    int n;
    if (t[30:23] < 8'd126) return 0;
    m = {8'd0, 1'b1, t[22:0]} >> (8'd149 - t[30:23]);  // 2*|t| truncated
    n = int'((m + 32'd1) >> 1);
    return t[31] ? -n : n;
  endfunction

  function automatic logic [31:0] i2f(input int n);
    logic [8:0]  m;
    logic [23:0] mm;
    int pos;
    if (n == 0) return 32'd0;
    m   = (n < 0) ? 9'(-n) : 9'(n);
    pos = 0;
    for (int i = 0; i < 9; i++) if (m[i]) pos = i;
    mm  = {m, 15'd0} << (8 - pos);
    return {n < 0, 8'(127 + pos), mm[22:0]};
  endfunction

  function automatic logic [31:0] horner_c(input int k);
    case (k)
      0:       return 32'h3AB60B61;  // 1/720
      1:       return 32'h3C088889;  // 1/120
      2:       return 32'h3D2AAAAB;  // 1/24
      3:       return 32'h3E2AAAAB;  // 1/6
      4:       return 32'h3F000000;  // 1/2
      default: return c_ONE;
    endcase
  endfunction

  // exp(a) = 2^n * e^r, n = round(a*log2(e)), r = a - n*ln2 with ln2 split
  // hi/lo so n*hi is exact; e^r by a degree-7 Taylor polynomial.
  function automatic logic [31:0] fexp(input logic [31:0] a);
    logic [31:0] t, nf, r, p;
    logic signed [11:0] e2;
    int n;
    if (is_nan(a)) return c_QNAN;
    if (a[30:23] >= 8'd134) return a[31] ? 32'd0 : 32'h7F800000;  // |a| >= 128
    t  = fmul(a, 32'h3FB8AA3B);
    n  = f2i(t);
    nf = i2f(n);
    r  = fadd(fadd(a, fmul(nf, 32'hBF317180)), fmul(nf, 32'hB717F7D1));
    p  = 32'h39500D01;  // 1/5040
    for (int k = 0; k < 7; k++) p = fadd(fmul(p, r), horner_c(k));
    e2 = $signed({4'd0, p[30:23]}) + $signed(12'(n));
    if (e2 >= 12'sd255)   return 32'h7F800000;
    else if (e2 <= 12'sd0) return 32'd0;
    else                   return {1'b0, e2[7:0], p[22:0]};
  endfunction

  function automatic logic [31:0] fsigmoid(input logic [31:0] a);
    return frecip(fadd(c_ONE, fexp({~a[31], a[30:0]})));
  endfunction

  // ------------------------------- datapath ---------------------------------
  typedef enum logic [2:0] {S_IDLE, S_L1, S_ACT, S_L2, S_DONE} state_t;

  state_t         r_state;
  logic [K1W-1:0] r_k1;
  logic [K2W-1:0] r_jk;   // hidden index: neuron in ACT, input in L2
  logic           r_done;
  logic [31:0]    r_acc1 [LAYER2_NEURONS];
  logic [31:0]    r_h    [LAYER2_NEURONS];
  logic [31:0]    r_acc2 [OUTPUT_NODES];
  logic [31:0]    r_y    [OUTPUT_NODES];
  logic [31:0]    w_acc1_nxt [LAYER2_NEURONS];
  logic [31:0]    w_acc2_nxt [OUTPUT_NODES];
  logic [31:0]    w_sig;

  for (genvar j = 0; j < LAYER2_NEURONS; j++) begin : g_l1_mac
    assign w_acc1_nxt[j] = fadd(r_acc1[j], fmul(bus.x[r_k1], bus.W1[r_k1][j]));
  end
  for (genvar i = 0; i < OUTPUT_NODES; i++) begin : g_l2_mac
    assign w_acc2_nxt[i] = fadd(r_acc2[i], fmul(r_h[r_jk], bus.W2[r_jk][i]));
    assign bus.y[i]      = r_y[i];
  end
  assign w_sig    = fsigmoid(r_acc1[r_jk]);  // single shared activation unit
  assign bus.done = r_done;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_k1    <= '0;
      r_jk    <= '0;
      r_done  <= 1'b0;
      for (int j = 0; j < LAYER2_NEURONS; j++) begin
        r_acc1[j] <= '0;
        r_h[j]    <= '0;
      end
      for (int i = 0; i < OUTPUT_NODES; i++) begin
        r_acc2[i] <= '0;
        r_y[i]    <= '0;
      end
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (bus.start) begin
          for (int j = 0; j < LAYER2_NEURONS; j++) r_acc1[j] <= bus.b1[j];
          r_k1    <= '0;
          r_state <= S_L1;
        end
        S_L1: begin
          for (int j = 0; j < LAYER2_NEURONS; j++) r_acc1[j] <= w_acc1_nxt[j];
          if (r_k1 == c_L1_LAST) begin
            r_k1    <= '0;
            r_jk    <= '0;
            r_state <= S_ACT;
          end else r_k1 <= r_k1 + 1'b1;
        end
        S_ACT: begin
          r_h[r_jk] <= w_sig;
          if (r_jk == c_L2_LAST) begin
            for (int i = 0; i < OUTPUT_NODES; i++) r_acc2[i] <= bus.b2[i];
            r_jk    <= '0;
            r_state <= S_L2;
          end else r_jk <= r_jk + 1'b1;
        end
        S_L2: begin
          for (int i = 0; i < OUTPUT_NODES; i++) r_acc2[i] <= w_acc2_nxt[i];
          if (r_jk == c_L2_LAST) begin
            // y and done are registered on entry so both are valid in DONE.
            for (int i = 0; i < OUTPUT_NODES; i++) r_y[i] <= w_acc2_nxt[i];
            r_done  <= 1'b1;
            r_jk    <= '0;
            r_state <= S_DONE;
          end else r_jk <= r_jk + 1'b1;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_single_predict.sv
`default_nettype none
// ============================================================================
//  Module      : tb_single_predict
//  Description : Directed self-checking bench for single_predict.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_single_predict;
  localparam int L1 = 784;
  localparam int L2 = 50;
  localparam int NO = 10;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  single_predict_if #(.LAYER1_NEURONS(L1), .LAYER2_NEURONS(L2), .OUTPUT_NODES(NO)) bus ();
  single_predict #(.LAYER1_NEURONS(L1), .LAYER2_NEURONS(L2), .OUTPUT_NODES(NO)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int n_pass  = 0;
  int n_total = 0;
  int first_c, last_c, n_done;

  logic [31:0] fl_int [NO] = '{32'h00000000, 32'h3F800000, 32'h40000000, 32'h40400000,
                               32'h40800000, 32'h40A00000, 32'h40C00000, 32'h40E00000,
                               32'h41000000, 32'h41100000};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic check_near(input string tag, input logic [31:0] obs, input logic [31:0] exp,
                            input int tol);
    int d;
    d = int'(obs) - int'(exp);
    if (d < 0) d = -d;
    n_total++;
    assert (d <= tol) n_pass++;
    else $error("FAIL %s: observed %h expected %h (+/-%0d ulp)", tag, obs, exp, tol);
  endtask

  task automatic clear_inputs();
    for (int k = 0; k < L1; k++) begin
      bus.x[k] = '0;
      for (int j = 0; j < L2; j++) bus.W1[k][j] = '0;
    end
    for (int j = 0; j < L2; j++) begin
      bus.b1[j] = '0;
      for (int i = 0; i < NO; i++) bus.W2[j][i] = '0;
    end
    for (int i = 0; i < NO; i++) bus.b2[i] = '0;
  endtask

  // Cycle c is the c-th cycle after the edge that samples start; sampled at
  // its negedge. Optional busy re-start, back-to-back restart, mid-run reset.
  task automatic run(input int busy_at, input int rst_at, input bit b2b,
                     output int first, output int last, output int cnt);
    first = 0; last = 0; cnt = 0;
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    for (int c = 1; c <= 2000; c++) begin
      if (c > 1) @(negedge clk);
      if (bus.done === 1'b1) begin
        cnt++;
        if (first == 0) first = c;
        last = c;
      end
      bus.start = (c == busy_at) || (b2b && first != 0 && c == first + 1);
      if (rst_at > 0 && c == rst_at)     rstn = 1'b0;
      if (rst_at > 0 && c == rst_at + 5) rstn = 1'b1;
    end
    bus.start = 1'b0;
  endtask

  initial begin
    bus.start = 1'b0;
    clear_inputs();

    // Reset, with a start pulse while reset is held (must be ignored).
    repeat (5) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    for (int i = 0; i < NO; i++) check($sformatf("rst_y%0d", i), bus.y[i], 32'd0);
    rstn = 1'b1;
    n_done = 0;
    repeat (1000) begin
      @(negedge clk);
      if (bus.done === 1'b1) n_done++;
    end
    check("idle_no_done", n_done, 0);

    // Biases only: y = b2.
    for (int i = 0; i < NO; i++) bus.b2[i] = fl_int[i];
    run(0, 0, 1'b0, first_c, last_c, n_done);
    check("bias_latency", first_c, 885);
    check("bias_ndone", n_done, 1);
    for (int i = 0; i < NO; i++) check($sformatf("bias_y%0d", i), bus.y[i], fl_int[i]);

    // Start re-pulsed while busy.
    run(100, 0, 1'b0, first_c, last_c, n_done);
    check("busy_latency", first_c, 885);
    check("busy_ndone", n_done, 1);
    check("busy_y9", bus.y[9], 32'h41100000);

    // Back-to-back: start in the cycle after DONE.
    run(0, 0, 1'b1, first_c, last_c, n_done);
    check("b2b_first", first_c, 885);
    check("b2b_second", last_c, 1771);
    check("b2b_ndone", n_done, 2);

    // Saturated and neutral hidden units: h0=1, h1=0, h[2..49]=0.5.
    clear_inputs();
    bus.b1[0] = 32'h42C80000;  // 100.0
    bus.b1[1] = 32'hC3480000;  // -200.0
    bus.b2[3] = 32'hC1C80000;  // -25.0
    for (int k = 0; k < L2; k++) begin
      bus.W2[k][1] = 32'h3F800000;
      bus.W2[k][2] = 32'h40000000;
      bus.W2[k][3] = 32'h3F800000;
      bus.W2[k][6] = 32'hBF800000;
    end
    bus.W2[0][4] = 32'h3F800000;
    bus.W2[1][5] = 32'h3F800000;
    run(0, 0, 1'b0, first_c, last_c, n_done);
    check("sat_latency", first_c, 885);
    check("sat_y0", bus.y[0], 32'h00000000);
    check("sat_y1", bus.y[1], 32'h41C80000);  // 1 + 0 + 48*0.5
    check("sat_y2", bus.y[2], 32'h42480000);  // 2*(1 + 24)
    check("sat_y3", bus.y[3], 32'h00000000);  // -25 + 25 -> +0
    check("sat_y4", bus.y[4], 32'h3F800000);  // h0
    check("sat_y5", bus.y[5], 32'h00000000);  // h1
    check("sat_y6", bus.y[6], 32'hC1C80000);  // -25

    // Mid-run reset in L1.
    run(0, 400, 1'b0, first_c, last_c, n_done);
    check("abort_ndone", n_done, 0);
    for (int i = 0; i < NO; i++) check($sformatf("abort_y%0d", i), bus.y[i], 32'd0);

    // Single path: y0 = sigmoid(2.0) = 0.88079708.
    clear_inputs();
    for (int k = 0; k < L1; k++) bus.x[k] = 32'h3F800000;
    bus.W1[0][0] = 32'h40000000;
    bus.W2[0][0] = 32'h3F800000;
    run(0, 0, 1'b0, first_c, last_c, n_done);
    check("path_latency", first_c, 885);
    check("path_ndone", n_done, 1);
    check_near("path_y0", bus.y[0], 32'h3F617BEB, 16);
    for (int i = 1; i < NO; i++) check($sformatf("path_y%0d", i), bus.y[i], 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/single_predict.md
# single_predict

Two-layer fully-connected neural-network inference engine (784-50-10 by default) operating on IEEE-754 single-precision values. It computes hidden = sigmoid(x·W1 + b1) and outputs y = hidden·W2 + b2, which are raw pre-softmax scores; classification is argmax(y), taken downstream. It sits between the image/weight loader and the classifier logic, and is started by a one-cycle `start` pulse.

## Interface
- `LAYER1_NEURONS`, default 784: input vector length.
- `LAYER2_NEURONS`, default 50: hidden neuron count.
- `OUTPUT_NODES`, default 10: output score count.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rstn`  in  1: reset, asynchronous, active-low.
- `start`  in  1: one-cycle request, sampled only in IDLE.
- `x`  in  [31:0] × LAYER1_NEURONS: input vector, binary32.
- `W1`  in  [31:0] × [LAYER1_NEURONS][LAYER2_NEURONS]: layer-1 weights, binary32.
- `b1`  in  [31:0] × LAYER2_NEURONS: layer-1 biases, binary32.
- `W2`  in  [31:0] × [LAYER2_NEURONS][OUTPUT_NODES]: layer-2 weights, binary32.
- `b2`  in  [31:0] × OUTPUT_NODES: layer-2 biases, binary32.
- `done`  out  1: one-cycle pulse marking that `y` has just been updated.
- `y`  out  [31:0] × OUTPUT_NODES: registered output scores, binary32.

## Operation
- The module does not latch inputs. The driver holds `x`, `W1`, `b1`, `W2` and `b2` stable from the `start` edge until `done`.
- Arithmetic uses the team's combinational single-precision multiply and add cells, round-to-nearest-even. Sigmoid is 1/(1+exp(−a)), built from the team's combinational fp exp and divide cells; one shared unit.
- Accumulation order is fixed, so results are bit-reproducible: the accumulator starts at the bias, then adds products in ascending input index.
- The FSM has five states:
  - IDLE: wait for `start`. On `start`, acc1[j] ← b1[j] for all j, k ← 0, go to L1.
  - L1: each cycle, acc1[j] ← acc1[j] + x[k]·W1[k][j] for all j in parallel (LAYER2_NEURONS MACs). k increments; after k = LAYER1_NEURONS−1 go to ACT with j ← 0.
  - ACT: each cycle, h[j] ← sigmoid(acc1[j]), j increments. After the last j, acc2[i] ← b2[i] for all i, k ← 0, go to L2.
  - L2: each cycle, acc2[i] ← acc2[i] + h[k]·W2[k][i] for all i in parallel. After the last k go to DONE.
  - DONE: y ← acc2, `done` = 1 for this cycle, then return to IDLE.
- `start` is ignored outside IDLE.
- `y` holds its value until the next DONE.
- NaN/Inf propagate per the fp cells; no exception flags are produced.

## Timing
- Reset values: `y` all 0x00000000, `done` 0, FSM in IDLE, internal accumulators 0.
- Latency is fixed at LAYER1_NEURONS + LAYER2_NEURONS + LAYER2_NEURONS + 1 cycles. For defaults that is 885 cycles: `done` is high in the 885th cycle after the edge that sampled `start`, and `y` is valid in that same cycle.
- Back-to-back: a `start` in the cycle after DONE is accepted.
- Reset asserted mid-operation aborts immediately. `y` clears to zero, no `done` is produced, and the next `start` after release runs normally.
- `start` asserted simultaneously with `rstn` low is ignored.

## Test plan
- **Reset:** pulse `rstn` low for 10 cycles → `y` all 0, `done` 0, and no `done` within 1000 cycles without `start`.
- **Biases only:**
  - Stimulus: x, W1, b1, W2 all 0; b2[i] = float(i); pulse `start`.
  - Response: `done` exactly once, 885 cycles later.
  - y[0]=0x00000000, y[1]=0x3F800000, y[9]=0x41100000.
- **Single path:**
  - Stimulus: x all 1.0; W1[0][0]=2.0, others 0; b1=0; W2[0][0]=1.0, others 0; b2=0.
  - Response: y[0] ≈ 0.8807971 (within 1 ulp-scale 1e-6); y[1..9]=0.
- **Busy start:** re-pulse `start` 100 cycles into a run → a single `done` at 885; no second run.
- **Mid-run reset:** assert `rstn` low at cycle 400 of L1 → no `done`; `y`=0; a fresh `start` then completes at 885 with correct values.
- **Real network:**
  - Stimulus: trained MNIST weights; training image 0 scaled to pixel/255.0.
  - Response: `y` matches a double-precision reference within 1e-4 relative, and argmax(y)=5.
